// File: rtl/seek_sequencer.sv
// -----------------------------------------------------------------------------
// seek_sequencer
//
// Head-positioning controller for a stepper-driven floppy head. Accepts seek
// and recalibrate commands on a valid/ready handshake, produces active-low
// step pulses of programmable width and rate, tracks the current cylinder and
// uses the track-0 sensor to find a known position.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   cmd_valid    in   command present
//   cmd_ready    out  high only while idle
//   cmd_recal    in   1 = recalibrate, 0 = seek
//   cmd_track    in   seek target cylinder (ignored for recalibrate)
//   tr0          in   track-0 sensor, active-high, asynchronous
//   step         out  active-low step pulse to the driver, idles high
//   dir          out  0 = toward center (track+1), 1 = toward edge (track-1)
//   en           out  driver enable, high from acceptance through DONE
//   busy         out  high whenever not idle
//   done         out  one-cycle completion pulse
//   error        out  sticky error, cleared by the next accepted command
//   track_valid  out  cur_track reflects the real head position
//   cur_track    out  current cylinder
//
// Build option
//   TR0_CHECK_EN  when defined, seeks cross-check the track-0 sensor: an
//                 outward seek that finds tr0 early snaps to cylinder 0 with
//                 an error, and a seek that ends on cylinder 0 without tr0
//                 flags an error and invalidates the position. When undefined
//                 tr0 is used only by recalibrate.
//
// States
//   state      | meaning
//   -----------+--------------------------------------------------------
//   IDLE       | waiting for a command, cmd_ready high
//   DIR_SETUP  | dir settled, waiting before the first step falls
//   STEP_LO    | step pulse low
//   STEP_HI    | step high between pulses; next move decided at its end
//   SETTLE     | head settle time after the last step
//   DONE       | completion, done pulse follows on the next cycle
// -----------------------------------------------------------------------------
module seek_sequencer #(
    parameter int unsigned STEP_LOW_CYCLES  = 64,
    parameter int unsigned STEP_HIGH_CYCLES = 2000,
    parameter int unsigned DIR_SETUP_CYCLES = 8,
    parameter int unsigned SETTLE_CYCLES    = 5000,
    parameter int unsigned MAX_TRACK        = 79,
    parameter int unsigned RECAL_LIMIT      = 84
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_recal,
    input  logic [6:0] cmd_track,
    input  logic       tr0,
    output logic       step,
    output logic       dir,
    output logic       en,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       track_valid,
    output logic [6:0] cur_track
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DIR_SETUP = 3'd1;
    localparam logic [2:0] S_STEP_LO   = 3'd2;
    localparam logic [2:0] S_STEP_HI   = 3'd3;
    localparam logic [2:0] S_SETTLE    = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    // The timer counts down to zero, so each timed state loads length-1.
    localparam logic [15:0] DIR_SETUP_LD = 16'(DIR_SETUP_CYCLES - 1);
    localparam logic [15:0] STEP_LO_LD   = 16'(STEP_LOW_CYCLES - 1);
    localparam logic [15:0] STEP_HI_LD   = 16'(STEP_HIGH_CYCLES - 1);
    localparam logic [15:0] SETTLE_LD    = 16'(SETTLE_CYCLES - 1);
    localparam logic [6:0]  MAX_TRK      = 7'(MAX_TRACK);
    localparam logic [15:0] RECAL_LIM    = 16'(RECAL_LIMIT);

    logic [2:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [6:0]  target_q, target_d;
    logic [6:0]  cur_track_q, cur_track_d;
    logic        recal_q, recal_d;
    logic        step_q, step_d;
    logic        dir_q, dir_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        track_valid_q, track_valid_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        tr0_meta_q, tr0_sync_q;
    logic        timer_expired;

    assign timer_expired = (timer_q == 16'd0);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_expired ? 16'd0 : timer_q - 16'd1;
        step_cnt_d    = step_cnt_q;
        target_d      = target_q;
        cur_track_d   = cur_track_q;
        recal_d       = recal_q;
        dir_d         = dir_q;
        error_d       = error_q;
        track_valid_d = track_valid_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    error_d = 1'b0;
                    recal_d = cmd_recal;
                    if (cmd_recal) begin
                        if (tr0_sync_q) begin
                            // Already sitting on track 0: no motion needed.
                            cur_track_d   = 7'd0;
                            track_valid_d = 1'b1;
                            state_d       = S_SETTLE;
                            timer_d       = SETTLE_LD;
                        end else begin
                            dir_d      = 1'b1;
                            step_cnt_d = 16'd0;
                            state_d    = S_DIR_SETUP;
                            timer_d    = DIR_SETUP_LD;
                        end
                    end else if (!track_valid_q || (cmd_track > MAX_TRK)) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else if (cmd_track == cur_track_q) begin
                        state_d = S_DONE;
                    end else begin
                        target_d = cmd_track;
                        dir_d    = (cmd_track < cur_track_q);
                        state_d  = S_DIR_SETUP;
                        timer_d  = DIR_SETUP_LD;
                    end
                end
            end

            S_DIR_SETUP: begin
                if (timer_expired) begin
                    state_d = S_STEP_LO;
                    timer_d = STEP_LO_LD;
                end
            end

            S_STEP_LO: begin
                if (timer_expired) begin
                    state_d = S_STEP_HI;
                    timer_d = STEP_HI_LD;
                    if (recal_q) begin
                        step_cnt_d = step_cnt_q + 16'd1;
                    end else if (dir_q) begin
                        // Seek targets are range-checked, so these guards
                        // only matter if the position was corrupted.
                        if (cur_track_q != 7'd0) cur_track_d = cur_track_q - 7'd1;
                    end else begin
                        if (cur_track_q != MAX_TRK) cur_track_d = cur_track_q + 7'd1;
                    end
                end
            end

            S_STEP_HI: begin
                if (timer_expired) begin
                    if (recal_q) begin
                        if (tr0_sync_q) begin
                            cur_track_d   = 7'd0;
                            track_valid_d = 1'b1;
                            state_d       = S_SETTLE;
                            timer_d       = SETTLE_LD;
                        end else if (step_cnt_q >= RECAL_LIM) begin
                            error_d       = 1'b1;
                            track_valid_d = 1'b0;
                            state_d       = S_DONE;
                        end else begin
                            state_d = S_STEP_LO;
                            timer_d = STEP_LO_LD;
                        end
                    end else begin
`ifdef TR0_CHECK_EN
                        if (dir_q && tr0_sync_q && (cur_track_q != 7'd0)) begin
                            // Head reached the stop before the count said so.
                            cur_track_d = 7'd0;
                            error_d     = 1'b1;
                            state_d     = S_SETTLE;
                            timer_d     = SETTLE_LD;
                        end else if (cur_track_q == target_q) begin
                            if ((target_q == 7'd0) && !tr0_sync_q) begin
                                error_d       = 1'b1;
                                track_valid_d = 1'b0;
                            end
                            state_d = S_SETTLE;
                            timer_d = SETTLE_LD;
                        end else begin
                            state_d = S_STEP_LO;
                            timer_d = STEP_LO_LD;
                        end
`else
                        if (cur_track_q == target_q) begin
                            state_d = S_SETTLE;
                            timer_d = SETTLE_LD;
                        end else begin
                            state_d = S_STEP_LO;
                            timer_d = STEP_LO_LD;
                        end
`endif
                    end
                end
            end

            S_SETTLE: begin
                if (timer_expired) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                timer_d = 16'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so step width and dir setup
    // time line up exactly with the timed states. done is taken one cycle
    // after the DONE state.
    always_comb begin
        step_d      = (state_d != S_STEP_LO);
        en_d        = (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        cmd_ready_d = (state_d == S_IDLE);
        done_d      = (state_q == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            timer_q       <= 16'd0;
            step_cnt_q    <= 16'd0;
            target_q      <= 7'd0;
            cur_track_q   <= 7'd0;
            recal_q       <= 1'b0;
            step_q        <= 1'b1;
            dir_q         <= 1'b0;
            en_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            track_valid_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            tr0_meta_q    <= 1'b0;
            tr0_sync_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            step_cnt_q    <= step_cnt_d;
            target_q      <= target_d;
            cur_track_q   <= cur_track_d;
            recal_q       <= recal_d;
            step_q        <= step_d;
            dir_q         <= dir_d;
            en_q          <= en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            track_valid_q <= track_valid_d;
            cmd_ready_q   <= cmd_ready_d;
            tr0_meta_q    <= tr0;
            tr0_sync_q    <= tr0_meta_q;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign step        = step_q;
    assign dir         = dir_q;
    assign en          = en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign track_valid = track_valid_q;
    assign cur_track   = cur_track_q;

endmodule

// File: tb/tb_seek_sequencer.sv
module tb_seek_sequencer;

    localparam int LO   = 30;
    localparam int HI   = 4;
    localparam int DS   = 3;
    localparam int ST   = 12;
    localparam int MAXT = 79;
    localparam int RL   = 84;
    localparam int P    = LO + HI;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_recal;
    logic [6:0] cmd_track;
    logic       tr0;
    logic       step;
    logic       dir;
    logic       en;
    logic       busy;
    logic       done;
    logic       error;
    logic       track_valid;
    logic [6:0] cur_track;

    seek_sequencer #(
        .STEP_LOW_CYCLES (LO),
        .STEP_HIGH_CYCLES(HI),
        .DIR_SETUP_CYCLES(DS),
        .SETTLE_CYCLES   (ST),
        .MAX_TRACK       (MAXT),
        .RECAL_LIMIT     (RL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_recal  (cmd_recal),
        .cmd_track  (cmd_track),
        .tr0        (tr0),
        .step       (step),
        .dir        (dir),
        .en         (en),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .track_valid(track_valid),
        .cur_track  (cur_track)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: where the head is believed to be.
    int m_cur = 0;
    bit m_tv  = 1'b0;
    bit m_err = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_step"}, int'(step), 1);
        chk({tag, "_dir"}, int'(dir), 0);
        chk({tag, "_en"}, int'(en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_tv"}, int'(track_valid), 0);
        chk({tag, "_cur"}, int'(cur_track), 0);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
    endtask

    // k (recal only): -1 = tr0 never asserts, 0 = tr0 already high at
    // acceptance, n>0 = tr0 rises after the n-th step pulse.
    task automatic run_cmd(input bit recal, input int trk, input int k);
        int  e_pulses, e_lat, hold, lim, done_idx, pulses, lowlen;
        int  widthbad, dirbad, readybad, enbad;
        bit  e_dir, seen, prev_step;

        e_pulses = 0;
        e_dir    = dir;
        if (recal) begin
            e_dir = 1'b1;
            if (k == 0) begin
                e_lat = 2 + ST;
                m_cur = 0; m_tv = 1'b1; m_err = 1'b0;
            end else if (k < 0) begin
                e_pulses = RL;
                e_lat    = 2 + DS + RL * P;
                m_tv = 1'b0; m_err = 1'b1;
            end else begin
                e_pulses = k;
                e_lat    = 2 + DS + k * P + ST;
                m_cur = 0; m_tv = 1'b1; m_err = 1'b0;
            end
        end else begin
            if (!m_tv || trk > MAXT) begin
                e_lat = 2; m_err = 1'b1;
            end else if (trk == m_cur) begin
                e_lat = 2; m_err = 1'b0;
            end else begin
                e_dir    = (trk < m_cur);
                e_pulses = (trk > m_cur) ? trk - m_cur : m_cur - trk;
                e_lat    = 2 + DS + e_pulses * P + ST;
                m_cur    = trk;
                m_err    = 1'b0;
            end
        end

        tr0 = recal ? (k == 0) : 1'($urandom % 2);
        repeat (3) @(negedge clk);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_recal = recal;
        cmd_track = 7'(trk);
        lim  = (e_lat - 1 > 20) ? 20 : e_lat - 1;
        hold = $urandom_range(0, lim);

        seen = 1'b0; done_idx = -1; pulses = 0; lowlen = 0; prev_step = 1'b1;
        widthbad = 0; dirbad = 0; readybad = 0; enbad = 0;
        for (int i = 1; i <= e_lat + 20 && !seen; i++) begin
            @(negedge clk);
            if (i > hold) begin
                cmd_valid = 1'b0;
            end else begin
                cmd_recal = 1'($urandom % 2);
                cmd_track = 7'($urandom);
            end
            if (done) begin
                seen = 1'b1;
                done_idx = i;
            end else begin
                if (cmd_ready) readybad++;
                if (i < e_lat && !en) enbad++;
            end
            if (!step && prev_step) begin
                pulses++;
                lowlen = 1;
            end else if (!step) begin
                lowlen++;
            end else if (!prev_step && lowlen != LO) begin
                widthbad++;
            end
            if (!step && dir != e_dir) dirbad++;
            if (recal && k > 0 && pulses == k && step) tr0 = 1'b1;
            prev_step = step;
        end
        cmd_valid = 1'b0;

        chk("done_latency", done_idx, e_lat);
        chk("pulse_count", pulses, e_pulses);
        chk("pulse_width_bad", widthbad, 0);
        chk("dir_while_step_bad", dirbad, 0);
        chk("ready_while_busy", readybad, 0);
        chk("en_while_busy", enbad, 0);
        chk("cur_track", int'(cur_track), m_cur);
        chk("track_valid", int'(track_valid), int'(m_tv));
        chk("error", int'(error), int'(m_err));
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("error_sticky", int'(error), int'(m_err));
        chk("step_idle", int'(step), 1);
    endtask

    initial begin
        int r, trk, found;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_recal = 1'b0;
        cmd_track = 7'd0;
        tr0 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("after_reset");

        // Seek before any recalibrate is rejected.
        run_cmd(1'b0, $urandom_range(1, MAXT), 0);
        // Recalibrate finding track 0 after three pulses.
        run_cmd(1'b1, 0, 3);
        run_cmd(1'b0, 5, 0);
        run_cmd(1'b0, 2, 0);
        run_cmd(1'b0, 80, 0);
        run_cmd(1'b0, 2, 0);
        run_cmd(1'b1, 0, 0);

        for (int n = 0; n < 10; n++) begin
            r = $urandom % 4;
            if (r == 0) begin
                run_cmd(1'b1, 0, $urandom_range(0, 5));
            end else begin
                if ($urandom % 8 == 0)      trk = $urandom_range(80, 127);
                else if ($urandom % 6 == 0) trk = m_cur;
                else                         trk = $urandom_range(0, MAXT);
                run_cmd(1'b0, trk, 0);
            end
        end

        // Sensor stuck low: recalibrate gives up after RL pulses.
        run_cmd(1'b1, 0, -1);
        run_cmd(1'b0, 10, 0);

        // Reset in the middle of a low step pulse.
        run_cmd(1'b1, 0, 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_recal = 1'b0;
        cmd_track = 7'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (!step) found = 1;
        end
        chk("step_low_seen", found, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        m_cur = 0; m_tv = 1'b0; m_err = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_cmd(1'b1, 0, 2);
        run_cmd(1'b0, 7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
